// File: rtl/gauss_filter_mc.sv
// gauss_filter_mc: multi-channel 3x3 kernel stage (bypass / Gaussian 1-2-1 / sharpen).
// Three register stages, sync signals delayed to match. The kernel is latched at the
// start of each frame and carried down the pipe alongside each pixel.
module gauss_filter_mc #(
    parameter int DATA_W = 8,
    parameter int CH     = 1,
    parameter int ROUND  = 1,
    parameter int VS_POL = 1
) (
    input  logic                     video_clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode_i,
    input  logic                     matrix_de,
    input  logic                     matrix_vs,
    input  logic                     matrix_hs,
    input  logic [9*CH*DATA_W-1:0]   matrix_in,
    output logic                     filt_vs,
    output logic                     filt_hs,
    output logic                     filt_de,
    output logic [CH*DATA_W-1:0]     filt_data,
    output logic [1:0]               active_mode
);

    localparam logic [1:0] MODE_BYP = 2'd0;
    localparam logic [1:0] MODE_GAU = 2'd1;
    localparam logic [1:0] MODE_SHP = 2'd2;
    localparam logic       VS_ACT   = (VS_POL != 0) ? 1'b1 : 1'b0;
    // Rounding offset added before the divide-by-16 of the Gaussian sum.
    localparam logic [DATA_W+3:0] RND = (ROUND != 0) ? (DATA_W+4)'(8) : (DATA_W+4)'(0);
    localparam logic signed [DATA_W+3:0] PIX_MAX = $signed({4'b0000, {DATA_W{1'b1}}});

    // Frame-start detection and mode selection
    logic        vs_prev_r;
    logic        vs_start_s;
    logic [1:0]  mode_req_s;
    logic [1:0]  mode_in_s;
    logic [1:0]  active_mode_r;

    // Sync delay lines
    logic [2:0]  de_d_r;
    logic [2:0]  vs_d_r;
    logic [2:0]  hs_d_r;

    // Pipeline mode tags
    logic [1:0]  mode1_r;
    logic [1:0]  mode2_r;

    // Per-channel taps and stage-1 partials
    logic [DATA_W-1:0]  tap_s [CH][9];
    logic [DATA_W+3:0]  r1_s  [CH];
    logic [DATA_W+3:0]  r2_s  [CH];
    logic [DATA_W+3:0]  r3_s  [CH];
    logic [DATA_W+2:0]  p_s   [CH];
    logic [DATA_W+1:0]  n_s   [CH];

    logic [DATA_W+3:0]  r1_r  [CH];
    logic [DATA_W+3:0]  r2_r  [CH];
    logic [DATA_W+3:0]  r3_r  [CH];
    logic [DATA_W+2:0]  p_r   [CH];
    logic [DATA_W+1:0]  n_r   [CH];
    logic [DATA_W-1:0]  byp1_r[CH];

    // Stage-2 results
    logic [DATA_W+3:0]         sum_r [CH];
    logic signed [DATA_W+3:0]  s_r   [CH];
    logic [DATA_W-1:0]         byp2_r[CH];

    // Stage-3 result and output register
    logic [CH*DATA_W-1:0] res_s;
    logic [CH*DATA_W-1:0] filt_data_r;

    assign vs_start_s = (matrix_vs == VS_ACT) && (vs_prev_r != VS_ACT);
    assign mode_req_s = (mode_i == 2'd3) ? MODE_BYP : mode_i;
    // A pixel arriving together with the frame start already uses the new kernel.
    assign mode_in_s  = vs_start_s ? mode_req_s : active_mode_r;

    // Frame-start edge tracking and per-frame kernel latch
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_r     <= 1'b0;
            active_mode_r <= MODE_BYP;
        end else begin
            vs_prev_r <= matrix_vs;
            if (vs_start_s) begin
                active_mode_r <= mode_req_s;
            end
        end
    end

    // Sync shift registers and mode tags travelling with the data
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d_r  <= 3'b000;
            vs_d_r  <= 3'b000;
            hs_d_r  <= 3'b000;
            mode1_r <= MODE_BYP;
            mode2_r <= MODE_BYP;
        end else begin
            de_d_r  <= {de_d_r[1:0], matrix_de};
            vs_d_r  <= {vs_d_r[1:0], matrix_vs};
            hs_d_r  <= {hs_d_r[1:0], matrix_hs};
            mode1_r <= mode_in_s;
            mode2_r <= mode1_r;
        end
    end

    // Unpack the window and form row partials / sharpen terms
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < 9; k++) begin
                tap_s[c][k] = matrix_in[(c*9+k)*DATA_W +: DATA_W];
            end
            r1_s[c] = {4'b0000, tap_s[c][0]} + {3'b000, tap_s[c][1], 1'b0} + {4'b0000, tap_s[c][2]};
            r2_s[c] = {3'b000, tap_s[c][3], 1'b0} + {2'b00, tap_s[c][4], 2'b00}
                    + {3'b000, tap_s[c][5], 1'b0};
            r3_s[c] = {4'b0000, tap_s[c][6]} + {3'b000, tap_s[c][7], 1'b0} + {4'b0000, tap_s[c][8]};
            p_s[c]  = {1'b0, tap_s[c][4], 2'b00} + {3'b000, tap_s[c][4]};
            n_s[c]  = {2'b00, tap_s[c][1]} + {2'b00, tap_s[c][3]}
                    + {2'b00, tap_s[c][5]} + {2'b00, tap_s[c][7]};
        end
    end

    // Stage 1: capture partials for valid windows, zero otherwise
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                r1_r[c]   <= '0;
                r2_r[c]   <= '0;
                r3_r[c]   <= '0;
                p_r[c]    <= '0;
                n_r[c]    <= '0;
                byp1_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (matrix_de) begin
                    r1_r[c]   <= r1_s[c];
                    r2_r[c]   <= r2_s[c];
                    r3_r[c]   <= r3_s[c];
                    p_r[c]    <= p_s[c];
                    n_r[c]    <= n_s[c];
                    byp1_r[c] <= tap_s[c][4];
                end else begin
                    r1_r[c]   <= '0;
                    r2_r[c]   <= '0;
                    r3_r[c]   <= '0;
                    p_r[c]    <= '0;
                    n_r[c]    <= '0;
                    byp1_r[c] <= '0;
                end
            end
        end
    end

    // Stage 2: Gaussian sum and signed sharpen difference
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                sum_r[c]  <= '0;
                s_r[c]    <= '0;
                byp2_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                sum_r[c]  <= r1_r[c] + r2_r[c] + r3_r[c];
                s_r[c]    <= $signed({1'b0, p_r[c]}) - $signed({2'b00, n_r[c]});
                byp2_r[c] <= byp1_r[c];
            end
        end
    end

    // Stage 3 combinational: normalise / clamp / pass through per the pixel's mode
    always_comb begin
        res_s = '0;
        for (int c = 0; c < CH; c++) begin
            case (mode2_r)
                MODE_GAU: res_s[c*DATA_W +: DATA_W] = DATA_W'((sum_r[c] + RND) >> 4);
                MODE_SHP: begin
                    if (s_r[c] < $signed((DATA_W+4)'(0))) begin
                        res_s[c*DATA_W +: DATA_W] = '0;
                    end else if (s_r[c] > PIX_MAX) begin
                        res_s[c*DATA_W +: DATA_W] = {DATA_W{1'b1}};
                    end else begin
                        res_s[c*DATA_W +: DATA_W] = s_r[c][DATA_W-1:0];
                    end
                end
                default:  res_s[c*DATA_W +: DATA_W] = byp2_r[c];
            endcase
        end
    end

    // Output register, blanked whenever the delayed de is low
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_data_r <= '0;
        end else if (de_d_r[1]) begin
            filt_data_r <= res_s;
        end else begin
            filt_data_r <= '0;
        end
    end

    assign filt_data   = filt_data_r;
    assign filt_de     = de_d_r[2];
    assign filt_vs     = vs_d_r[2];
    assign filt_hs     = hs_d_r[2];
    assign active_mode = active_mode_r;

endmodule
